// File: rtl/fifo_pkg.sv
// Shared helpers for the FIFO family: pointer sizing and parameter legality checks.
package fifo_pkg;

    function automatic int unsigned ptr_width(input int unsigned depth);
        return $clog2(depth);
    endfunction

    function automatic bit depth_legal(input int unsigned depth);
        return (depth >= 2) && ((depth & (depth - 1)) == 0);
    endfunction

    function automatic bit thresh_legal(input int unsigned depth,
                                        input int unsigned almost_full,
                                        input int unsigned almost_empty);
        return (almost_full >= 1) && (almost_full <= depth) && (almost_empty < depth);
    endfunction

endpackage

// File: rtl/fifo_mem.sv
// Simple dual-port storage array: synchronous write, asynchronous read, no reset.
module fifo_mem
    import fifo_pkg::*;
#(
    parameter int unsigned MEM_LENGTH = 32,
    parameter int unsigned DATA_WIDTH = 16
) (
    input  logic                                clk_i,
    input  logic                                write_en_i,
    input  logic [ptr_width(MEM_LENGTH)-1:0]    write_addr_i,
    input  logic [DATA_WIDTH-1:0]               write_data_i,
    input  logic [ptr_width(MEM_LENGTH)-1:0]    read_addr_i,
    output logic [DATA_WIDTH-1:0]               read_data_o
);

    logic [DATA_WIDTH-1:0] mem_q [MEM_LENGTH];

    always_ff @(posedge clk_i) begin
        if (write_en_i) begin
            mem_q[write_addr_i] <= write_data_i;
        end
    end

    assign read_data_o = mem_q[read_addr_i];

endmodule

// File: rtl/fifo_sync.sv
// Single-clock FIFO with occupancy count, almost-full/empty thresholds, sticky
// overflow/underflow flags, synchronous clear and selectable FWFT read mode.
module fifo_sync
    import fifo_pkg::*;
#(
    parameter int unsigned MEM_LENGTH          = 32,
    parameter int unsigned DATA_WIDTH          = 16,
    parameter bit          FWFT                = 1'b0,
    parameter int unsigned ALMOST_FULL_THRESH  = MEM_LENGTH - 4,
    parameter int unsigned ALMOST_EMPTY_THRESH = 4
) (
    input  logic                              clk_i,
    input  logic                              reset_ni,
    input  logic                              clear_i,
    input  logic                              write_en_i,
    input  logic                              read_en_i,
    input  logic [DATA_WIDTH-1:0]             data_i,
    output logic [DATA_WIDTH-1:0]             data_o,
    output logic                              full_o,
    output logic                              empty_o,
    output logic                              almost_full_o,
    output logic                              almost_empty_o,
    output logic [ptr_width(MEM_LENGTH):0]    count_o,
    output logic                              overflow_o,
    output logic                              underflow_o
);

    localparam int unsigned PtrW = ptr_width(MEM_LENGTH);
    localparam int unsigned CntW = PtrW + 1;

    localparam logic [CntW-1:0] FullCount   = CntW'(MEM_LENGTH);
    localparam logic [CntW-1:0] AfThresh    = CntW'(ALMOST_FULL_THRESH);
    localparam logic [CntW-1:0] AeThresh    = CntW'(ALMOST_EMPTY_THRESH);

    if (!depth_legal(MEM_LENGTH)) begin : g_bad_depth
        $error("fifo_sync: MEM_LENGTH must be a power of two >= 2");
    end
    if (!thresh_legal(MEM_LENGTH, ALMOST_FULL_THRESH, ALMOST_EMPTY_THRESH)) begin : g_bad_thresh
        $error("fifo_sync: almost-full/almost-empty threshold out of range");
    end

    logic [PtrW-1:0]       wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]       count_q, count_d;
    logic                  overflow_q, underflow_q;
    logic                  full, empty;
    logic                  wr_accept, rd_accept;
    logic [DATA_WIDTH-1:0] rd_data;

    assign full  = (count_q == FullCount);
    assign empty = (count_q == '0);

    // Clear wins over both requests; acceptance uses flags sampled at cycle start.
    assign wr_accept = write_en_i & ~full & ~clear_i;
    assign rd_accept = read_en_i & ~empty & ~clear_i;

    always_comb begin
        count_d = count_q;
        case ({wr_accept, rd_accept})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else if (clear_i) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (wr_accept) wr_ptr_q <= wr_ptr_q + PtrW'(1);
            if (rd_accept) rd_ptr_q <= rd_ptr_q + PtrW'(1);
            count_q <= count_d;
            if (write_en_i && full) overflow_q <= 1'b1;
            // A read colliding with a write into an empty FIFO is not an error.
            if (read_en_i && empty && !write_en_i) underflow_q <= 1'b1;
        end
    end

    fifo_mem #(
        .MEM_LENGTH (MEM_LENGTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_mem (
        .clk_i        (clk_i),
        .write_en_i   (wr_accept),
        .write_addr_i (wr_ptr_q),
        .write_data_i (data_i),
        .read_addr_i  (rd_ptr_q),
        .read_data_o  (rd_data)
    );

    if (FWFT) begin : g_fwft
        assign data_o = rd_data;
    end else begin : g_reg_read
        logic [DATA_WIDTH-1:0] data_q;

        always_ff @(posedge clk_i or negedge reset_ni) begin
            if (!reset_ni) begin
                data_q <= '0;
            end else if (clear_i) begin
                data_q <= '0;
            end else if (rd_accept) begin
                data_q <= rd_data;
            end
        end

        assign data_o = data_q;
    end

    assign full_o         = full;
    assign empty_o        = empty;
    assign almost_full_o  = (count_q >= AfThresh);
    assign almost_empty_o = (count_q <= AeThresh);
    assign count_o        = count_q;
    assign overflow_o     = overflow_q;
    assign underflow_o    = underflow_q;

endmodule

// File: tb/tb_fifo_sync.sv
// Directed bench: registered-read instance and FWFT instance, depth 8, thresholds 6/2.
module tb_fifo_sync;

    logic clk;
    logic rst_n;

    logic        r_clear, r_we, r_re;
    logic [15:0] r_din, r_dout;
    logic        r_full, r_empty, r_af, r_ae, r_ovf, r_udf;
    logic [3:0]  r_count;

    logic        f_clear, f_we, f_re;
    logic [15:0] f_din, f_dout;
    logic        f_full, f_empty, f_af, f_ae, f_ovf, f_udf;
    logic [3:0]  f_count;

    int errors = 0;
    int checks = 0;

    fifo_sync #(
        .MEM_LENGTH (8), .DATA_WIDTH (16), .FWFT (1'b0),
        .ALMOST_FULL_THRESH (6), .ALMOST_EMPTY_THRESH (2)
    ) u_reg (
        .clk_i (clk), .reset_ni (rst_n), .clear_i (r_clear),
        .write_en_i (r_we), .read_en_i (r_re), .data_i (r_din), .data_o (r_dout),
        .full_o (r_full), .empty_o (r_empty), .almost_full_o (r_af),
        .almost_empty_o (r_ae), .count_o (r_count),
        .overflow_o (r_ovf), .underflow_o (r_udf)
    );

    fifo_sync #(
        .MEM_LENGTH (8), .DATA_WIDTH (16), .FWFT (1'b1),
        .ALMOST_FULL_THRESH (6), .ALMOST_EMPTY_THRESH (2)
    ) u_fwft (
        .clk_i (clk), .reset_ni (rst_n), .clear_i (f_clear),
        .write_en_i (f_we), .read_en_i (f_re), .data_i (f_din), .data_o (f_dout),
        .full_o (f_full), .empty_o (f_empty), .almost_full_o (f_af),
        .almost_empty_o (f_ae), .count_o (f_count),
        .overflow_o (f_ovf), .underflow_o (f_udf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        r_clear = 0; r_we = 0; r_re = 0; r_din = '0;
        f_clear = 0; f_we = 0; f_re = 0; f_din = '0;
        repeat (3) step();
        rst_n = 1'b1;
        #1;
        checks++; if (r_empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b want 1", r_empty); end
        checks++; if (r_count !== 4'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", r_count); end
        checks++; if (r_dout !== 16'h0) begin errors++; $display("FAIL reset_data: got %h want 0000", r_dout); end
        checks++; if (r_ae !== 1'b1) begin errors++; $display("FAIL reset_almost_empty: got %b want 1", r_ae); end
        checks++; if ({r_full, r_af, r_ovf, r_udf} !== 4'b0000)
            begin errors++; $display("FAIL reset_other_flags: got %b want 0000", {r_full, r_af, r_ovf, r_udf}); end
        checks++; if ({f_empty, f_count} !== 5'b1_0000)
            begin errors++; $display("FAIL reset_fwft_empty_count: got %b want 10000", {f_empty, f_count}); end
    endtask

    task automatic test_fill_overflow();
        for (int i = 1; i <= 8; i++) begin
            r_we = 1; r_din = 16'(i);
            step();
            checks++; if (r_count !== 4'(i)) begin errors++; $display("FAIL fill_count[%0d]: got %0d want %0d", i, r_count, i); end
            checks++; if (r_ae !== (i <= 2)) begin errors++; $display("FAIL fill_almost_empty[%0d]: got %b want %b", i, r_ae, (i <= 2)); end
            checks++; if (r_af !== (i >= 6)) begin errors++; $display("FAIL fill_almost_full[%0d]: got %b want %b", i, r_af, (i >= 6)); end
            checks++; if (r_full !== (i == 8)) begin errors++; $display("FAIL fill_full[%0d]: got %b want %b", i, r_full, (i == 8)); end
        end
        r_din = 16'h0009;
        step();
        r_we = 0;
        checks++; if (r_ovf !== 1'b1) begin errors++; $display("FAIL overflow_flag: got %b want 1", r_ovf); end
        checks++; if (r_count !== 4'd8) begin errors++; $display("FAIL overflow_count: got %0d want 8", r_count); end
    endtask

    task automatic test_drain_underflow();
        for (int i = 1; i <= 8; i++) begin
            r_re = 1;
            step();
            checks++; if (r_dout !== 16'(i)) begin errors++; $display("FAIL drain_data[%0d]: got %h want %h", i, r_dout, 16'(i)); end
            checks++; if (r_empty !== (i == 8)) begin errors++; $display("FAIL drain_empty[%0d]: got %b want %b", i, r_empty, (i == 8)); end
        end
        step();
        r_re = 0;
        checks++; if (r_udf !== 1'b1) begin errors++; $display("FAIL underflow_flag: got %b want 1", r_udf); end
        checks++; if (r_dout !== 16'h0008) begin errors++; $display("FAIL underflow_data_hold: got %h want 0008", r_dout); end
        checks++; if (r_count !== 4'd0) begin errors++; $display("FAIL underflow_count: got %0d want 0", r_count); end
    endtask

    task automatic test_simultaneous();
        r_clear = 1; step(); r_clear = 0;
        // Both at empty: write accepted, read rejected, no underflow.
        r_we = 1; r_re = 1; r_din = 16'h0050;
        step();
        checks++; if (r_count !== 4'd1) begin errors++; $display("FAIL simul_empty_count: got %0d want 1", r_count); end
        checks++; if (r_udf !== 1'b0) begin errors++; $display("FAIL simul_empty_underflow: got %b want 0", r_udf); end
        r_re = 0; r_din = 16'h0051; step();
        r_din = 16'h0052; step();
        r_re = 1; r_din = 16'h0053;
        step();
        checks++; if (r_count !== 4'd3) begin errors++; $display("FAIL simul_mid_count: got %0d want 3", r_count); end
        checks++; if (r_dout !== 16'h0050) begin errors++; $display("FAIL simul_mid_data: got %h want 0050", r_dout); end
        r_re = 0;
        for (int i = 0; i < 5; i++) begin
            r_din = 16'h0054 + 16'(i);
            step();
        end
        checks++; if (r_full !== 1'b1) begin errors++; $display("FAIL simul_prefull: got %b want 1", r_full); end
        r_re = 1; r_din = 16'h00EE;
        step();
        r_we = 0;
        checks++; if (r_count !== 4'd7) begin errors++; $display("FAIL simul_full_count: got %0d want 7", r_count); end
        checks++; if (r_dout !== 16'h0051) begin errors++; $display("FAIL simul_full_data: got %h want 0051", r_dout); end
        for (int i = 0; i < 7; i++) begin
            step();
            checks++; if (r_dout !== 16'h0052 + 16'(i))
                begin errors++; $display("FAIL simul_order[%0d]: got %h want %h", i, r_dout, 16'h0052 + 16'(i)); end
        end
        r_re = 0;
        checks++; if (r_empty !== 1'b1) begin errors++; $display("FAIL simul_drained: got %b want 1", r_empty); end
    endtask

    task automatic test_fwft_stream();
        logic [15:0] q[$];
        int nw = 0;
        int nr = 0;
        bit acc_w, acc_r;
        for (int cyc = 0; cyc < 400 && nr < 20; cyc++) begin
            checks++; if (f_empty !== (q.size() == 0))
                begin errors++; $display("FAIL stream_empty[%0d]: got %b want %b", cyc, f_empty, (q.size() == 0)); end
            checks++; if (f_count !== 4'(q.size()))
                begin errors++; $display("FAIL stream_count[%0d]: got %0d want %0d", cyc, f_count, q.size()); end
            checks++; if (f_count > 4'd8) begin errors++; $display("FAIL stream_count_max[%0d]: got %0d want <=8", cyc, f_count); end
            if (q.size() > 0) begin
                checks++; if (f_dout !== q[0])
                    begin errors++; $display("FAIL stream_data[%0d]: got %h want %h", cyc, f_dout, q[0]); end
            end
            f_we  = (nw < 20) && ($urandom_range(0, 2) != 0);
            f_re  = ($urandom_range(0, 2) != 0);
            f_din = 16'h0100 + 16'(nw);
            acc_w = f_we && (q.size() < 8);
            acc_r = f_re && (q.size() > 0);
            step();
            if (acc_r) begin void'(q.pop_front()); nr++; end
            if (acc_w) begin q.push_back(f_din); nw++; end
        end
        f_we = 0; f_re = 0;
        checks++; if (nr != 20) begin errors++; $display("FAIL stream_complete: got %0d want 20 words read", nr); end
        f_we = 1; f_din = 16'h00A5;
        step();
        f_we = 0;
        checks++; if (f_empty !== 1'b0) begin errors++; $display("FAIL fwft_a5_empty: got %b want 0", f_empty); end
        checks++; if (f_dout !== 16'h00A5) begin errors++; $display("FAIL fwft_a5_data: got %h want 00a5", f_dout); end
        checks++; if (f_count !== 4'd1) begin errors++; $display("FAIL fwft_a5_count: got %0d want 1", f_count); end
    endtask

    task automatic test_clear();
        r_we = 1;
        for (int i = 0; i < 9; i++) begin
            r_din = 16'h0061 + 16'(i);
            step();
        end
        r_we = 0; r_re = 1;
        repeat (3) step();
        r_re = 0;
        checks++; if (r_count !== 4'd5) begin errors++; $display("FAIL preclear_count: got %0d want 5", r_count); end
        checks++; if (r_ovf !== 1'b1) begin errors++; $display("FAIL preclear_overflow: got %b want 1", r_ovf); end
        checks++; if (r_dout !== 16'h0063) begin errors++; $display("FAIL preclear_data: got %h want 0063", r_dout); end
        r_clear = 1; r_we = 1; r_re = 1; r_din = 16'h0077;
        step();
        r_clear = 0; r_we = 0; r_re = 0;
        checks++; if (r_count !== 4'd0) begin errors++; $display("FAIL clear_count: got %0d want 0", r_count); end
        checks++; if (r_empty !== 1'b1) begin errors++; $display("FAIL clear_empty: got %b want 1", r_empty); end
        checks++; if (r_ovf !== 1'b0) begin errors++; $display("FAIL clear_overflow: got %b want 0", r_ovf); end
        checks++; if (r_dout !== 16'h0000) begin errors++; $display("FAIL clear_data: got %h want 0000", r_dout); end
        step();
        checks++; if (r_count !== 4'd0) begin errors++; $display("FAIL clear_write_ignored: got %0d want 0", r_count); end
    endtask

    initial begin
        test_reset();
        test_fill_overflow();
        test_drain_underflow();
        test_simultaneous();
        test_fwft_stream();
        test_clear();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
